// File: rtl/ndn_pkg.sv
// ndn_pkg: shared definitions for the PIT<->FIB link.
//   PREFIX_W / LEN_W : default prefix and prefix-length widths.
//   tx_state_t       : PIT->FIB transmit FSM states.
//   rx_state_t       : FIB->PIT offer/receive FSM states.
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DRIVE,
        TX_GAP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_LOOKUP,
        RX_ACCEPT,
        RX_REJECT,
        RX_DATA,
        RX_PUSH
    } rx_state_t;

endpackage

// File: rtl/pit_fib_link_if.sv
// pit_fib_link_if: the wires between the PIT-side link endpoint and the FIB.
//   master : PIT side (drives pit_in_*, fib_out_bit, start_send_to_pit, rejected)
//   slave  : FIB side (drives prefix_ready, pit_out_*, out_data)
interface pit_fib_link_if #(
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W    = ndn_pkg::LEN_W
);

    logic [PREFIX_W-1:0] pit_in_prefix;
    logic [LEN_W-1:0]    pit_in_len;
    logic                fib_out_bit;
    logic                prefix_ready;
    logic [PREFIX_W-1:0] pit_out_prefix;
    logic [LEN_W-1:0]    pit_out_len;
    logic [7:0]          out_data;
    logic                start_send_to_pit;
    logic                rejected;

    modport master (
        output pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit, rejected,
        input  prefix_ready, pit_out_prefix, pit_out_len, out_data
    );

    modport slave (
        input  pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit, rejected,
        output prefix_ready, pit_out_prefix, pit_out_len, out_data
    );

endinterface

// File: rtl/ndn_prefix_mask.sv
// ndn_prefix_mask: keeps the top 'len' bits of an MSB-aligned prefix and
// clears the rest. len==0 and len>=PREFIX_W both pass the prefix through.
//   prefix : MSB-aligned input prefix
//   len    : prefix length in bits
//   masked : prefix with bits [PREFIX_W-1-len:0] cleared
module ndn_prefix_mask #(
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W    = ndn_pkg::LEN_W
) (
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [LEN_W-1:0]    len,
    output logic [PREFIX_W-1:0] masked
);

    always_comb begin
        masked = prefix;
        if (len != '0 && int'(len) < PREFIX_W) begin
            // All-ones shifted right by len leaves exactly the bits to clear.
            masked = prefix & ~({PREFIX_W{1'b1}} >> len);
        end
    end

endmodule

// File: rtl/pit_fib_link.sv
// pit_fib_link: PIT-side endpoint of the PIT<->FIB interface.
//   clk, rst            : clock, synchronous active-low reset
//   tx_valid/tx_ready   : PIT core hands over a prefix (tx_prefix, tx_len)
//   fib (master)        : link to the FIB (masked TX strobe, RX offers, payload bytes)
//   lookup_*            : PIT lookup of an offered prefix (level request, done/hit result)
//   rx_valid/rx_ready   : assembled entry (rx_prefix, rx_len, rx_payload) to the PIT core
//   tx_state, rx_state  : current FSM states, exported for observation
//
// Handshakes (tx_*, rx_*): a transfer happens on a rising edge where valid and
// ready are both high; the source holds its data stable while valid is high
// and ready is low, and valid never depends combinationally on ready.
module pit_fib_link
    import ndn_pkg::*;
#(
    parameter int PREFIX_W       = ndn_pkg::PREFIX_W,
    parameter int LEN_W          = ndn_pkg::LEN_W,
    parameter int PAYLOAD_BYTES  = 8,
    parameter int TX_GAP         = 2,
    parameter int LOOKUP_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [PREFIX_W-1:0]        tx_prefix,
    input  logic [LEN_W-1:0]           tx_len,
    pit_fib_link_if.master             fib,
    output logic                       lookup_req,
    output logic [PREFIX_W-1:0]        lookup_prefix,
    output logic [LEN_W-1:0]           lookup_len,
    input  logic                       lookup_done,
    input  logic                       lookup_hit,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [PREFIX_W-1:0]        rx_prefix,
    output logic [LEN_W-1:0]           rx_len,
    output logic [PAYLOAD_BYTES*8-1:0] rx_payload,
    output tx_state_t                  tx_state,
    output rx_state_t                  rx_state
);

    localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam int TO_W  = $clog2(LOOKUP_TIMEOUT + 1);
    localparam int BC_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    // ---------------- TX path ----------------
    tx_state_t           tx_state_q, tx_state_d;
    logic                tx_en_q;      // low in the cycle right after a reset edge
    logic [GAP_W-1:0]    gap_q;
    logic [PREFIX_W-1:0] tx_masked;
    logic [PREFIX_W-1:0] pit_in_prefix_q;
    logic [LEN_W-1:0]    pit_in_len_q;
    logic                tx_accept;
    logic                tx_ready_c;
    logic                fib_out_bit_c;

    ndn_prefix_mask #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) u_mask (
        .prefix (tx_prefix),
        .len    (tx_len),
        .masked (tx_masked)
    );

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_ready_c    = 1'b0;
        fib_out_bit_c = 1'b0;
        tx_accept     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_ready_c = tx_en_q;
                if (tx_valid && tx_en_q) begin
                    tx_accept  = 1'b1;
                    tx_state_d = TX_DRIVE;
                end
            end
            TX_DRIVE: begin
                fib_out_bit_c = 1'b1;
                tx_state_d    = ndn_pkg::TX_GAP;
            end
            ndn_pkg::TX_GAP: begin
                if (gap_q == GAP_W'(TX_GAP - 1)) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q      <= TX_IDLE;
            tx_en_q         <= 1'b0;
            gap_q           <= '0;
            pit_in_prefix_q <= '0;
            pit_in_len_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_en_q    <= 1'b1;
            gap_q      <= (tx_state_q == ndn_pkg::TX_GAP) ? gap_q + 1'b1 : '0;
            // pit_in_* stay put from the strobe until the next accept.
            if (tx_accept) begin
                pit_in_prefix_q <= tx_masked;
                pit_in_len_q    <= tx_len;
            end
        end
    end

    assign tx_ready          = tx_ready_c;
    assign fib.fib_out_bit   = fib_out_bit_c;
    assign fib.pit_in_prefix = pit_in_prefix_q;
    assign fib.pit_in_len    = pit_in_len_q;
    assign tx_state          = tx_state_q;

    // ---------------- RX path ----------------
    rx_state_t                  rx_state_q, rx_state_d;
    logic [TO_W-1:0]            to_q;
    logic [BC_W-1:0]            byte_q;
    logic [PREFIX_W-1:0]        cap_prefix_q;
    logic [LEN_W-1:0]           cap_len_q;
    logic [PAYLOAD_BYTES*8-1:0] payload_q;
    logic                       lookup_req_c, start_c, reject_c, rx_valid_c;

    always_comb begin
        rx_state_d   = rx_state_q;
        lookup_req_c = 1'b0;
        start_c      = 1'b0;
        reject_c     = 1'b0;
        rx_valid_c   = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (fib.prefix_ready) rx_state_d = RX_LOOKUP;
            RX_LOOKUP: begin
                lookup_req_c = 1'b1;
                // A result arriving in the last allowed cycle still counts.
                if (lookup_done)                             rx_state_d = lookup_hit ? RX_ACCEPT : RX_REJECT;
                else if (to_q == TO_W'(LOOKUP_TIMEOUT - 1)) rx_state_d = RX_REJECT;
            end
            RX_ACCEPT: begin
                start_c    = 1'b1;
                rx_state_d = RX_DATA;
            end
            RX_REJECT: begin
                reject_c   = 1'b1;
                rx_state_d = RX_IDLE;
            end
            RX_DATA: if (byte_q == BC_W'(PAYLOAD_BYTES - 1)) rx_state_d = RX_PUSH;
            RX_PUSH: begin
                rx_valid_c = 1'b1;
                if (rx_ready) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            to_q         <= '0;
            byte_q       <= '0;
            cap_prefix_q <= '0;
            cap_len_q    <= '0;
            payload_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_state_q == RX_IDLE && fib.prefix_ready) begin
                cap_prefix_q <= fib.pit_out_prefix;
                cap_len_q    <= fib.pit_out_len;
                payload_q    <= '0;
            end
            to_q   <= (rx_state_q == RX_LOOKUP) ? to_q + 1'b1 : '0;
            byte_q <= (rx_state_q == RX_DATA) ? byte_q + 1'b1 : '0;
            // Shifting in from the LSB end leaves byte 0 in the MSB byte once
            // all PAYLOAD_BYTES have arrived.
            if (rx_state_q == RX_DATA)
                payload_q <= {payload_q[PAYLOAD_BYTES*8-9:0], fib.out_data};
        end
    end

    assign lookup_req            = lookup_req_c;
    assign lookup_prefix         = cap_prefix_q;
    assign lookup_len            = cap_len_q;
    assign fib.start_send_to_pit = start_c;
    assign fib.rejected          = reject_c;
    assign rx_valid              = rx_valid_c;
    assign rx_prefix             = cap_prefix_q;
    assign rx_len                = cap_len_q;
    assign rx_payload            = payload_q;
    assign rx_state              = rx_state_q;

endmodule

// File: doc/pit_fib_link.md
Name: pit_fib_link

Overview:
- PIT-side endpoint of the PIT<->FIB interface; the opposite end of the FIB's PIT-facing ports.
- TX path: takes outgoing interest prefixes from the PIT core, masks them to length and presents them to the FIB (pit_in_prefix/pit_in_len/fib_out_bit).
- RX path: accepts FIB offers (prefix_ready/pit_out_prefix/pit_out_len), checks them against the PIT, answers start_send_to_pit or rejected, then collects out_data bytes into a buffer for the PIT core.

Parameters:
- PREFIX_W, 64, prefix width in bits.
- LEN_W, 6, prefix-length field width.
- PAYLOAD_BYTES, 8, bytes streamed on out_data per accepted offer.
- TX_GAP, 2, idle cycles after each fib_out_bit pulse.
- LOOKUP_TIMEOUT, 15, cycles to wait for lookup_done before rejecting.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- tx_valid  in  1  PIT core has a prefix to forward.
- tx_ready  out  1  TX path idle; accepts on tx_valid&&tx_ready.
- tx_prefix  in  PREFIX_W  prefix, MSB-aligned.
- tx_len  in  LEN_W  prefix length in bits.
- pit_in_prefix  out  PREFIX_W  masked prefix to FIB.
- pit_in_len  out  LEN_W  length to FIB.
- fib_out_bit  out  1  one-cycle strobe: pit_in_* valid.
- prefix_ready  in  1  FIB offers a prefix.
- pit_out_prefix  in  PREFIX_W  offered prefix.
- pit_out_len  in  LEN_W  offered length.
- out_data  in  8  payload byte stream from FIB.
- start_send_to_pit  out  1  one-cycle accept pulse.
- rejected  out  1  one-cycle reject pulse.
- lookup_req  out  1  PIT lookup request, level.
- lookup_prefix  out  PREFIX_W  captured offered prefix.
- lookup_len  out  LEN_W  captured offered length.
- lookup_done  in  1  PIT lookup result valid.
- lookup_hit  in  1  result; sampled only with lookup_done.
- rx_valid  out  1  assembled entry ready for the PIT core.
- rx_ready  in  1  PIT core consumes the entry.
- rx_prefix  out  PREFIX_W  entry prefix.
- rx_len  out  LEN_W  entry length.
- rx_payload  out  PAYLOAD_BYTES*8  entry payload; first byte in the MSB byte.

Behaviour:
- Reset (rst==0 at an edge): both FSMs go to idle; all outputs 0, including tx_ready; counters cleared; partial payload discarded. Reset mid-operation aborts with no pulse emitted. tx_ready=1 in the first cycle after release.
- Masking: out = in with bits [PREFIX_W-1-len:0] cleared. len=0 passes the prefix unmasked. len>=PREFIX_W is clamped to PREFIX_W (no masking).
- TX FSM: TX_IDLE -> TX_DRIVE -> TX_GAP -> TX_IDLE.
  - TX_IDLE: tx_ready=1. On accept, register the masked prefix and length.
  - TX_DRIVE (next cycle): fib_out_bit=1 for exactly 1 cycle. pit_in_prefix/pit_in_len are held from this cycle until the next accept.
  - TX_GAP: TX_GAP cycles with tx_ready=0.
  - Accept-to-strobe latency: 1 cycle. Back-to-back accepts are spaced TX_GAP+2 cycles apart.
- RX FSM: RX_IDLE -> RX_LOOKUP -> {RX_ACCEPT -> RX_DATA -> RX_PUSH | RX_REJECT} -> RX_IDLE.
  - RX_IDLE: prefix_ready=1 captures pit_out_prefix (unmasked) and pit_out_len.
  - RX_LOOKUP: lookup_req=1, holding lookup_prefix/lookup_len, until lookup_done. A timeout counter increments each cycle; reaching LOOKUP_TIMEOUT is treated as a miss.
  - lookup_done&&lookup_hit -> RX_ACCEPT: start_send_to_pit=1 for 1 cycle.
  - Miss or timeout -> RX_REJECT: rejected=1 for 1 cycle, then RX_IDLE. start_send_to_pit and rejected are never high together.
  - RX_DATA: starts the cycle after start_send_to_pit. Samples out_data on PAYLOAD_BYTES consecutive cycles; byte k goes to rx_payload[(PAYLOAD_BYTES-k)*8-1 -:8]; byte counter runs 0..PAYLOAD_BYTES-1.
  - RX_PUSH: rx_valid=1 with rx_* stable until rx_ready. Leaves on the rx_valid&&rx_ready cycle.
- prefix_ready outside RX_IDLE is ignored. The FIB re-offers the prefix; no queueing.
- TX and RX are fully independent; simultaneous tx accept and prefix_ready are both serviced in the same cycle.

Decomposition:
- Package ndn_pkg: PREFIX_W and LEN_W defaults, tx_state_t {TX_IDLE, TX_DRIVE, TX_GAP}, rx_state_t {RX_IDLE, RX_LOOKUP, RX_ACCEPT, RX_REJECT, RX_DATA, RX_PUSH}.
- Sub-module ndn_prefix_mask (combinational, prefix+len -> masked prefix), shared with the FIB.

Test Plan:
- TX single: tx_prefix=64'h0000FFFF0000FFFF, tx_len=48 -> one cycle later fib_out_bit=1 for 1 cycle, pit_in_prefix=64'h0000FFFF00000000, pit_in_len=48; tx_ready low for TX_GAP+1 cycles.
- TX back-to-back: tx_valid held with two prefixes -> strobes exactly 4 cycles apart (TX_GAP=2); len=0 passes the prefix unmasked; len=63 clears bit 0 only.
- RX hit: prefix_ready with 64'hA5A5..., len=32; lookup_done&&lookup_hit after 3 cycles -> one start_send_to_pit pulse; out_data=8'h01..8'h08 -> rx_payload=64'h0102030405060708, rx_valid held until rx_ready asserted 5 cycles later.
- RX miss and timeout: lookup_hit=0 -> rejected pulse, no start_send_to_pit. lookup_done never asserted -> rejected after 15 cycles. No rx_valid in either case.
- Concurrency/busy: TX accept in the same cycle as prefix_ready -> both progress. A second prefix_ready during RX_DATA is ignored, and the payload is unchanged.
- Reset mid-RX_DATA after 3 bytes: rst=0 for 1 cycle -> all outputs 0, no pulses; a new offer afterwards completes normally.
